// File: rtl/reg_wb_pkg.sv
// Shared types for the writeback block: register-address width, data width and the result record.
// The load FIFO and the writeback top both carry results as wb_result_t.
package reg_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_result_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_wb_fifo.sv
// Synchronous FIFO of wb_result_t, depth DEPTH (power of two, >= 2), head visible combinationally.
// Latency: a push at edge N is at the head in cycle N+1. Pushes while full and pops while empty are ignored.
module reg_wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_en,
    input  wb_result_t i_wr_dat,
    input  logic       i_rd_en,
    output wb_result_t o_rd_dat,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    wb_result_t  r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Extra MSB on each pointer separates the full case from the empty case.
    assign o_empty  = (r_wptr == r_rptr);
    assign o_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push   = i_wr_en && !o_full;
    assign w_pop    = i_rd_en && !o_empty;
    assign o_rd_dat = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_dat;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter (ALU first, then buffered loads) plus RAW scoreboard; 1-cycle ALU, >=2-cycle load latency.
// ALU results are never stalled; loads are held by the producer while ld_ready is low. REG_WB_BYPASS_EN adds source forwarding.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int XLEN     = reg_wb_pkg::XLEN,
    parameter int LQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
`ifdef REG_WB_BYPASS_EN
    output logic                  rs1_fwd_valid,
    output logic [XLEN-1:0]       rs1_fwd_data,
    output logic                  rs2_fwd_valid,
    output logic [XLEN-1:0]       rs2_fwd_data,
`endif
    output logic                  reg_write_en,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       write_data,
    output logic                  lq_full,
    output logic                  lq_empty
);

    wb_result_t w_alu_res;
    wb_result_t w_ld_res;
    wb_result_t w_head;
    wb_result_t w_sel;
    logic       w_lq_full;
    logic       w_lq_empty;
    logic       w_lq_push;
    logic       w_lq_pop;
    logic       w_sel_vld;
    logic       w_wr;

    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_pend_nxt;
    logic [NUM_REGS-1:0] r_pend;

    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_data;

    assign w_alu_res = '{rd: alu_rd, data: alu_data};
    assign w_ld_res  = '{rd: ld_rd,  data: ld_data};

    assign w_lq_push = ld_valid && !w_lq_full;
    assign w_lq_pop  = !alu_valid && !w_lq_empty;

    reg_wb_fifo #(
        .DEPTH    (LQ_DEPTH)
    ) u_lq (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (w_lq_push),
        .i_wr_dat (w_ld_res),
        .i_rd_en  (w_lq_pop),
        .o_rd_dat (w_head),
        .o_full   (w_lq_full),
        .o_empty  (w_lq_empty)
    );

    // The ALU has no backpressure, so it always wins; the FIFO head only drains on ALU-idle cycles.
    assign w_sel_vld = alu_valid || !w_lq_empty;
    assign w_sel     = alu_valid ? w_alu_res : w_head;
    assign w_wr      = w_sel_vld && (w_sel.rd != '0);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && (issue_rd != '0)) w_set = rd_onehot(issue_rd);
        if (w_wr)                            w_clr = rd_onehot(w_sel.rd);
        // Set is applied after clear so a re-issue of the same register stays pending.
        w_pend_nxt    = (r_pend & ~w_clr) | w_set;
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            r_we   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_we   <= w_wr;
            if (w_wr) begin
                r_rd   <= w_sel.rd;
                r_data <= w_sel.data;
            end
        end
    end

    assign reg_write_en = r_we;
    assign rd           = r_rd;
    assign write_data   = r_data;
    assign lq_full      = w_lq_full;
    assign lq_empty     = w_lq_empty;
    assign ld_ready     = !w_lq_full;

`ifdef REG_WB_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1        = w_wr && (w_sel.rd == rs1);
    assign w_fwd2        = w_wr && (w_sel.rd == rs2);
    assign rs1_fwd_valid = w_fwd1;
    assign rs2_fwd_valid = w_fwd2;
    assign rs1_fwd_data  = w_sel.data;
    assign rs2_fwd_data  = w_sel.data;
    assign rs1_busy      = r_pend[rs1] && !w_fwd1;
    assign rs2_busy      = r_pend[rs2] && !w_fwd2;
`else
    assign rs1_busy      = r_pend[rs1];
    assign rs2_busy      = r_pend[rs2];
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised bench for reg_writeback: a queue-based reference model predicts writes and status,
// a negedge monitor pops the expected-write queue whenever the write port is active.
module tb_reg_writeback;

    localparam int XLEN     = 32;
    localparam int LQ_DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_rd = '0;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            ld_valid = 1'b0;
    logic [4:0]      ld_rd = '0;
    logic [XLEN-1:0] ld_data = '0;
    logic            ld_ready;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            reg_write_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;
    logic            lq_full;
    logic            lq_empty;
`ifdef REG_WB_BYPASS_EN
    logic            rs1_fwd_valid;
    logic [XLEN-1:0] rs1_fwd_data;
    logic            rs2_fwd_valid;
    logic [XLEN-1:0] rs2_fwd_data;
`endif

    always #5 clk = ~clk;

    reg_writeback #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef REG_WB_BYPASS_EN
        .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
`endif
        .reg_write_en(reg_write_en), .rd(rd), .write_data(write_data),
        .lq_full(lq_full), .lq_empty(lq_empty)
    );

    typedef struct { int unsigned cyc; logic [4:0] rd; logic [XLEN-1:0] data; } exp_t;
    typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } res_t;

    exp_t        exp_q[$];
    res_t        m_lq[$];
    bit          m_pend[32];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every active write must be the next expected one, in the expected cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_write_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {59'd0, rd}, 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    chk("wr_rd", 64'(rd), 64'(e.rd));
                    chk("wr_data", 64'(write_data), 64'(e.data));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                chk("missing_write", 64'(exp_q[0].rd), 64'hFFFF_FFFF);
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle: drive inputs, check combinational outputs against the model, advance the model.
    task automatic step(input bit av, input int ard, input logic [XLEN-1:0] ad,
                        input bit lv, input int lrd, input logic [XLEN-1:0] ldd,
                        input bit iv, input int ird, input int r1, input int r2,
                        output bit accepted);
        bit              ready_e, have_w;
        res_t            w;
        bit              b1, b2;
        @(posedge clk);
        #1;
        alu_valid = av;   alu_rd = 5'(ard);   alu_data = ad;
        ld_valid  = lv;   ld_rd  = 5'(lrd);   ld_data  = ldd;
        issue_valid = iv; issue_rd = 5'(ird);
        rs1 = 5'(r1);     rs2 = 5'(r2);
        #1;
        ready_e = (m_lq.size() < LQ_DEPTH);
        chk("ld_ready", 64'(ld_ready), 64'(ready_e));
        chk("lq_full", 64'(lq_full), 64'(!ready_e));
        chk("lq_empty", 64'(lq_empty), 64'(m_lq.size() == 0));
        have_w = 1'b0;
        w = '{rd: 5'd0, data: '0};
        if (av) begin
            have_w = 1'b1;
            w = '{rd: 5'(ard), data: ad};
        end else if (m_lq.size() != 0) begin
            have_w = 1'b1;
            w = m_lq.pop_front();
        end
        b1 = m_pend[r1];
        b2 = m_pend[r2];
`ifdef REG_WB_BYPASS_EN
        chk("rs1_fwd_valid", 64'(rs1_fwd_valid), 64'(have_w && w.rd != 0 && int'(w.rd) == r1));
        chk("rs2_fwd_valid", 64'(rs2_fwd_valid), 64'(have_w && w.rd != 0 && int'(w.rd) == r2));
        if (have_w && w.rd != 0 && int'(w.rd) == r1) begin
            chk("rs1_fwd_data", 64'(rs1_fwd_data), 64'(w.data));
            b1 = 1'b0;
        end
        if (have_w && w.rd != 0 && int'(w.rd) == r2) begin
            chk("rs2_fwd_data", 64'(rs2_fwd_data), 64'(w.data));
            b2 = 1'b0;
        end
`endif
        chk("rs1_busy", 64'(rs1_busy), 64'(b1));
        chk("rs2_busy", 64'(rs2_busy), 64'(b2));
        if (have_w && w.rd != 0) begin
            exp_q.push_back('{cyc: cyc + 1, rd: w.rd, data: w.data});
            m_pend[w.rd] = 1'b0;
        end
        if (iv && ird != 0) m_pend[ird] = 1'b1;
        accepted = lv && ready_e;
        if (accepted) m_lq.push_back('{rd: 5'(lrd), data: ldd});
    endtask

    task automatic idle(input int n, input int r1);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, 0, 0, r1, 0, acc);
    endtask

    task automatic do_reset(input int r1);
        @(posedge clk);
        #1;
        alu_valid = 0; ld_valid = 0; issue_valid = 0;
        rs1 = 5'(r1); rs2 = 5'(r1);
        reset = 1'b1;
        m_lq.delete();
        exp_q.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        #1;
        chk("rst_we", 64'(reg_write_en), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_data", 64'(write_data), 64'd0);
        chk("rst_empty", 64'(lq_empty), 64'd1);
        chk("rst_full", 64'(lq_full), 64'd0);
        chk("rst_ready", 64'(ld_ready), 64'd1);
        chk("rst_busy1", 64'(rs1_busy), 64'd0);
        chk("rst_busy2", 64'(rs2_busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit              acc;
        int              k;
        bit              p_v;
        int              p_rd;
        logic [XLEN-1:0] p_d;

        do_reset(0);

        // ALU result lands one cycle later
        step(1, 5, 32'hDEAD_BEEF, 0, 0, '0, 0, 0, 5, 0, acc);
        idle(2, 5);

        // issue x7, watch it stay busy until the load writes it
        step(0, 0, '0, 0, 0, '0, 1, 7, 7, 7, acc);
        idle(3, 7);
        step(0, 0, '0, 1, 7, 32'h1234, 0, 0, 7, 7, acc);
        idle(4, 7);

        // load and ALU together: ALU first, load one cycle after
        step(0, 0, '0, 0, 0, '0, 1, 3, 3, 4, acc);
        step(0, 0, '0, 0, 0, '0, 1, 4, 3, 4, acc);
        step(1, 4, 32'h4444, 1, 3, 32'h3333, 0, 0, 3, 4, acc);
        idle(4, 3);

        // fill the FIFO while the ALU monopolises the port; fifth load is held
        k = 0;
        for (int c = 0; c < 8; c++) begin
            step(1, 20 + c, 32'hA000 + c, (k < 5), 10 + k, 32'hB000 + k, 0, 0, 10, 11, acc);
            if (acc) k++;
        end
        while (k < 5) begin
            step(0, 0, '0, 1, 10 + k, 32'hB000 + k, 0, 0, 10, 11, acc);
            if (acc) k++;
        end
        idle(8, 10);

        // x0 results are consumed silently
        step(1, 0, 32'hFFFF, 0, 0, '0, 0, 0, 0, 0, acc);
        step(0, 0, '0, 1, 0, 32'h5555, 0, 0, 0, 0, acc);
        idle(4, 0);

        // reset with three loads queued and pending bits set
        step(1, 1, 32'h1, 1, 12, 32'hC0, 1, 12, 12, 13, acc);
        step(1, 2, 32'h2, 1, 13, 32'hC1, 1, 13, 12, 13, acc);
        step(1, 3, 32'h3, 1, 14, 32'hC2, 1, 14, 12, 13, acc);
        do_reset(13);
        idle(6, 13);

        // randomised traffic with a load producer that holds unaccepted offers
        p_v = 0; p_rd = 0; p_d = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!p_v && ($urandom_range(0, 99) < 55)) begin
                p_v  = 1;
                p_rd = int'($urandom_range(0, 31));
                p_d  = $urandom();
            end
            step(($urandom_range(0, 99) < 50), int'($urandom_range(0, 31)), $urandom(),
                 p_v, p_rd, p_d,
                 ($urandom_range(0, 99) < 40), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), acc);
            if (acc) p_v = 0;
            if (c == 1000) do_reset(int'($urandom_range(0, 31)));
            if (c == 1000) p_v = 0;
        end
        idle(LQ_DEPTH + 4, 0);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
